// File: rtl/change_dispenser.sv
// Turns change amounts into single-coin eject requests for one hopper, tracks inventory, latches ack-timeout faults.
// Latency: eject_req rises 2 cycles after a new change event (capture, then IDLE decision); 1 coin per 1+wait+GAP_LEN+1 cycles.
// Backpressure: eject_req is held until eject_ack or ACK_TIMEOUT; owed coins wait in IDLE while the hopper is empty.
module change_dispenser #(
    parameter int unsigned COIN_VALUE  = 10,
    parameter int unsigned MAX_COINS   = 63,
    parameter int unsigned GAP_LEN     = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] change_in,
    input  logic       refill_valid,
    input  logic [5:0] refill_count,
    input  logic       eject_ack,
    output logic       eject_req,
    output logic       busy,
    output logic       empty,
    output logic       fault,
    output logic [5:0] coin_count,
    output logic [4:0] owed
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    logic [1:0]    state_q, state_d;
    logic          eject_req_q, eject_req_d;
    logic          fault_q, fault_d;
    logic          busy_q, busy_d;
    logic          arm_q, arm_d;
    logic [5:0]    coin_q, coin_d;
    logic [4:0]    owed_q, owed_d;
    logic [4:0]    change_q, change_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    logic          new_req;
    logic          ack_take;
    logic          refill_take;
    logic [4:0]    add_coins;
    logic [6:0]    owed_sum;
    logic [6:0]    coin_sum;

    always_comb begin
        change_d = change_in;
        // A change level already present when reset releases must fall to zero before it counts as an event.
        arm_d    = arm_q | (change_in == 5'd0);

        new_req     = (change_in != 5'd0) && (change_q == 5'd0) && arm_q && (state_q != S_FAULT);
        ack_take    = (state_q == S_REQ) && eject_ack;
        refill_take = refill_valid && (state_q != S_FAULT);
        add_coins   = 5'(32'(change_in) / COIN_VALUE);

        owed_sum = {2'b00, owed_q}
                 + (new_req  ? {2'b00, add_coins} : 7'd0)
                 - (ack_take ? 7'd1 : 7'd0);
        owed_d   = (owed_sum > 7'd31) ? 5'd31 : owed_sum[4:0];

        coin_sum = {1'b0, coin_q}
                 + (refill_take ? {1'b0, refill_count} : 7'd0)
                 - (ack_take ? 7'd1 : 7'd0);
        coin_d   = (coin_sum > 7'(MAX_COINS)) ? 6'(MAX_COINS) : coin_sum[5:0];

        state_d     = state_q;
        eject_req_d = eject_req_q;
        fault_d     = fault_q;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;

        case (state_q)
            S_IDLE: begin
                if ((owed_q != 5'd0) && (coin_q != 6'd0)) begin
                    state_d     = S_REQ;
                    eject_req_d = 1'b1;
                    tcnt_d      = '0;
                end
            end
            S_REQ: begin
                if (ack_take) begin
                    eject_req_d = 1'b0;
                    gcnt_d      = '0;
                    state_d     = (GAP_LEN == 0) ? S_IDLE : S_GAP;
                end else if ((32'(tcnt_q) + 32'd1) >= ACK_TIMEOUT) begin
                    eject_req_d = 1'b0;
                    fault_d     = 1'b1;
                    state_d     = S_FAULT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_GAP: begin
                if ((32'(gcnt_q) + 32'd1) >= GAP_LEN) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                eject_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) || (owed_d != 5'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            eject_req_q <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
            arm_q       <= 1'b0;
            coin_q      <= '0;
            owed_q      <= '0;
            change_q    <= '0;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            eject_req_q <= eject_req_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
            arm_q       <= arm_d;
            coin_q      <= coin_d;
            owed_q      <= owed_d;
            change_q    <= change_d;
            tcnt_q      <= tcnt_d;
            gcnt_q      <= gcnt_d;
        end
    end

    assign eject_req  = eject_req_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign coin_count = coin_q;
    assign owed       = owed_q;
    assign empty      = (coin_q == 6'd0);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: queue of expected coin ejects per change event, checked by an eject monitor.
module tb_change_dispenser;

    localparam int COIN_VALUE  = 10;
    localparam int MAX_COINS   = 63;
    localparam int GAP_LEN     = 2;
    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] change_in;
    logic       refill_valid;
    logic [5:0] refill_count;
    logic       eject_ack;
    logic       eject_req;
    logic       busy;
    logic       empty;
    logic       fault;
    logic [5:0] coin_count;
    logic [4:0] owed;

    int checks    = 0;
    int failures  = 0;
    int exp_q[$];
    int scen      = 0;
    int hold_left = 0;
    int rises     = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .COIN_VALUE (COIN_VALUE),
        .MAX_COINS  (MAX_COINS),
        .GAP_LEN    (GAP_LEN),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .change_in   (change_in),
        .refill_valid(refill_valid),
        .refill_count(refill_count),
        .eject_ack   (eject_ack),
        .eject_req   (eject_req),
        .busy        (busy),
        .empty       (empty),
        .fault       (fault),
        .coin_count  (coin_count),
        .owed        (owed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, then release any held change level whose hold count ran out.
    task automatic step();
        @(posedge clk);
        #1;
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) change_in = 5'd0;
        end
    endtask

    task automatic change_event(input int val, input int hold);
        change_in = 5'(val);
        hold_left = hold;
        repeat (val / COIN_VALUE) exp_q.push_back(scen);
    endtask

    task automatic do_refill(input int cnt);
        refill_valid = 1'b1;
        refill_count = 6'(cnt);
        step();
        refill_valid = 1'b0;
        refill_count = 6'd0;
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (eject_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("req_within_budget", eject_req, 1);
    endtask

    task automatic ack_next(input int wait_cyc, input int budget);
        wait_req(budget);
        repeat (wait_cyc) step();
        eject_ack = 1'b1;
        step();
        eject_ack = 1'b0;
    endtask

    // Eject monitor: every rising eject_req consumes one expected coin and must follow the inter-coin gap.
    initial begin : monitor
        logic prev;
        logic have_fall;
        int   low_cnt;
        int   tag;
        prev      = 1'b0;
        have_fall = 1'b0;
        low_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1) begin
                prev      = 1'b0;
                have_fall = 1'b0;
                low_cnt   = 0;
            end else begin
                if (!prev && eject_req === 1'b1) begin
                    rises++;
                    chk("eject_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        tag = exp_q.pop_front();
                        chk("eject_scenario", tag, scen);
                    end
                    if (have_fall) chk("eject_gap_ok", (low_cnt >= GAP_LEN + 1), 1);
                end else if (prev && eject_req !== 1'b1) begin
                    have_fall = 1'b1;
                    low_cnt   = 1;
                end else if (eject_req !== 1'b1) begin
                    low_cnt++;
                end
                prev = (eject_req === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int r0;
        int n;
        rst          = 1'b0;
        change_in    = 5'd0;
        refill_valid = 1'b0;
        refill_count = 6'd0;
        eject_ack    = 1'b0;
        repeat (3) step();
        chk("rst_eject_req", eject_req, 0);
        chk("rst_fault", fault, 0);
        chk("rst_coin_count", coin_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_owed", owed, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        step();

        // Basic two-coin dispense from 20 cents.
        scen = 1;
        do_refill(5);
        chk("s1_coin_after_refill", coin_count, 5);
        chk("s1_not_empty", empty, 0);
        r0 = rises;
        change_event(20, 6);
        step();
        chk("s1_owed_captured", owed, 2);
        chk("s1_busy", busy, 1);
        ack_next(1, 10);
        chk("s1_owed_after_ack1", owed, 1);
        chk("s1_coin_after_ack1", coin_count, 4);
        chk("s1_req_dropped", eject_req, 0);
        ack_next(1, 10);
        chk("s1_owed_after_ack2", owed, 0);
        chk("s1_coin_after_ack2", coin_count, 3);
        repeat (4) step();
        chk("s1_busy_low", busy, 0);
        chk("s1_pulse_count", rises - r0, 2);

        // Empty hopper retains owed coin until refill.
        scen = 2;
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("s2_coin_zero", coin_count, 0);
        change_event(10, 3);
        step();
        chk("s2_owed", owed, 1);
        chk("s2_no_req", eject_req, 0);
        chk("s2_busy", busy, 1);
        chk("s2_empty", empty, 1);
        repeat (3) step();
        chk("s2_still_no_req", eject_req, 0);
        chk("s2_owed_retained", owed, 1);
        do_refill(4);
        chk("s2_coin_refilled", coin_count, 4);
        wait_req(2);
        eject_ack = 1'b1;
        step();
        eject_ack = 1'b0;
        chk("s2_coin_final", coin_count, 3);
        chk("s2_owed_final", owed, 0);
        repeat (4) step();
        chk("s2_busy_low", busy, 0);

        // Refill coincident with ack saturates at capacity.
        scen = 3;
        do_refill(59);
        chk("s3_coin_62", coin_count, 62);
        change_event(10, 2);
        wait_req(5);
        eject_ack    = 1'b1;
        refill_valid = 1'b1;
        refill_count = 6'd10;
        step();
        eject_ack    = 1'b0;
        refill_valid = 1'b0;
        refill_count = 6'd0;
        chk("s3_coin_saturated", coin_count, MAX_COINS);
        chk("s3_owed_decremented", owed, 0);
        repeat (4) step();
        do_refill(10);
        chk("s3_coin_stays_max", coin_count, MAX_COINS);

        // Two change events accumulate while the first eject is pending.
        scen = 4;
        r0 = rises;
        change_event(20, 2);
        step();
        step();
        step();
        change_event(10, 2);
        step();
        chk("s4_owed_accum", owed, 3);
        chk("s4_req_pending", eject_req, 1);
        ack_next(1, 10);
        ack_next(1, 10);
        ack_next(1, 10);
        repeat (4) step();
        chk("s4_owed_zero", owed, 0);
        chk("s4_coin", coin_count, 60);
        chk("s4_busy_low", busy, 0);
        chk("s4_pulse_count", rises - r0, 3);

        // Asynchronous reset mid-request; stale change level must not retrigger.
        scen = 5;
        change_event(10, 0);
        step();
        wait_req(5);
        #2 rst = 1'b0;
        #1;
        chk("s5_async_req_drop", eject_req, 0);
        chk("s5_rst_coin", coin_count, 0);
        chk("s5_rst_owed", owed, 0);
        chk("s5_rst_fault", fault, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_empty", empty, 1);
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("s5_stale_no_owed", owed, 0);
        chk("s5_stale_no_req", eject_req, 0);
        change_in = 5'd0;
        step();
        change_event(10, 2);
        step();
        chk("s5_rearmed_owed", owed, 1);
        do_refill(2);
        ack_next(0, 5);
        chk("s5_coin_after", coin_count, 1);
        chk("s5_owed_after", owed, 0);
        repeat (4) step();

        // Hopper never acks: timeout then sticky fault.
        scen = 6;
        change_event(10, 2);
        wait_req(5);
        n = 0;
        while (eject_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("s6_req_high_cycles", n, ACK_TIMEOUT);
        chk("s6_fault", fault, 1);
        chk("s6_req_low", eject_req, 0);
        chk("s6_owed_kept", owed, 1);
        chk("s6_busy", busy, 1);
        refill_valid = 1'b1;
        refill_count = 6'd5;
        eject_ack    = 1'b1;
        change_in    = 5'd30;
        hold_left    = 2;
        step();
        refill_valid = 1'b0;
        refill_count = 6'd0;
        eject_ack    = 1'b0;
        repeat (3) step();
        chk("s6_coin_frozen", coin_count, 1);
        chk("s6_owed_frozen", owed, 1);
        chk("s6_fault_sticky", fault, 1);
        chk("s6_req_stays_low", eject_req, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
